// File: rtl/uart_wb_host.sv
// rtl/uart_wb_host.sv - Wishbone slave that carries single 32-bit reads/writes over a UART command link
//
// uart_wb_host_tx : 8N1 transmitter; byte stream in (tdata_i/tvalid_i/tready_o), frame_end_o at end of stop bit
// uart_wb_host_rx : 8N1 receiver; 2-flop sync, start glitch reject, bad stop bit drops the byte
// uart_wb_host    : top
//   clock, reset                      system clock, synchronous active-high reset
//   wb_addr_i, wb_data_i, wb_we_i     request, latched when accepted
//   wb_cyc_i, wb_strobe_i             request qualifiers
//   wb_data_o                         last successful read data
//   wb_ack_o, wb_err_o                one-cycle completion / failure pulses
//   serial_tx, serial_rx              UART link to uart_wb_master

module uart_wb_host_tx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tdata_i,
    input  logic       tvalid_i,
    output logic       tready_o,
    output logic       frame_end_o,
    output logic       serial_tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    logic          busy_q;
    logic [CW-1:0] clk_cnt_q;
    logic [3:0]    bit_idx_q;
    logic [8:0]    shift_q;
    logic          tx_q;
    logic          bit_end;

    assign bit_end     = busy_q && (clk_cnt_q == BIT_LAST);
    assign frame_end_o = bit_end && (bit_idx_q == 4'd9);
    // Ready during the final stop-bit cycle so the next byte follows with no idle gap.
    assign tready_o    = !busy_q || frame_end_o;
    assign serial_tx   = tx_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q    <= 1'b0;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '1;
            tx_q      <= 1'b1;
        end else if (tvalid_i && tready_o) begin
            busy_q    <= 1'b1;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= {1'b1, tdata_i};
            tx_q      <= 1'b0;
        end else if (frame_end_o) begin
            busy_q    <= 1'b0;
            clk_cnt_q <= '0;
            tx_q      <= 1'b1;
        end else if (bit_end) begin
            clk_cnt_q <= '0;
            bit_idx_q <= bit_idx_q + 4'd1;
            tx_q      <= shift_q[0];
            shift_q   <= {1'b1, shift_q[8:1]};
        end else if (busy_q) begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
        end
    end
endmodule

module uart_wb_host_rx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_rx,
    output logic [7:0] tdata_o,
    output logic       tvalid_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic          sync1_q, sync2_q, prev_q;
    logic          busy_q;
    logic [CW-1:0] clk_cnt_q;
    logic [3:0]    bit_idx_q;   // 0 start check, 1..8 data, 9 stop
    logic [7:0]    shift_q;
    logic          tvalid_q;
    logic          sample;

    // Start bit is checked after half a bit; every later sample is a full bit apart, i.e. mid-bit.
    assign sample   = busy_q && (clk_cnt_q == ((bit_idx_q == 4'd0) ? HALF_LAST : BIT_LAST));
    assign tdata_o  = shift_q;
    assign tvalid_o = tvalid_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            busy_q    <= 1'b0;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tvalid_q  <= 1'b0;
        end else begin
            sync1_q  <= serial_rx;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            tvalid_q <= 1'b0;
            if (!busy_q) begin
                if (prev_q && !sync2_q) begin
                    busy_q    <= 1'b1;
                    clk_cnt_q <= '0;
                    bit_idx_q <= '0;
                end
            end else if (sample) begin
                clk_cnt_q <= '0;
                if (bit_idx_q == 4'd0) begin
                    if (sync2_q) busy_q <= 1'b0;   // glitch, not a start bit
                    else         bit_idx_q <= 4'd1;
                end else if (bit_idx_q == 4'd9) begin
                    busy_q   <= 1'b0;
                    tvalid_q <= sync2_q;           // framing error drops the byte
                end else begin
                    shift_q   <= {sync2_q, shift_q[7:1]};
                    bit_idx_q <= bit_idx_q + 4'd1;
                end
            end else begin
                clk_cnt_q <= clk_cnt_q + CW'(1);
            end
        end
    end
endmodule

module uart_wb_host #(
    parameter int CLKS_PER_BIT   = 104,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] wb_addr_i,
    input  logic [31:0] wb_data_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_strobe_i,
    output logic [31:0] wb_data_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        serial_tx,
    input  logic        serial_rx
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SEND = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_FAIL = 3'd4;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [3:0]    byte_idx_q, byte_idx_d;
    logic [1:0]    rcnt_q, rcnt_d;
    logic [31:0]   resp_q, resp_d, rdata_q, rdata_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic [7:0] tx_tdata, rx_tdata;
    logic       tx_tvalid, tx_tready, tx_frame_end, rx_tvalid;
    logic [3:0] n_bytes;

    uart_wb_host_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clock(clock), .reset(reset), .tdata_i(tx_tdata), .tvalid_i(tx_tvalid),
        .tready_o(tx_tready), .frame_end_o(tx_frame_end), .serial_tx(serial_tx)
    );

    uart_wb_host_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock(clock), .reset(reset), .serial_rx(serial_rx),
        .tdata_o(rx_tdata), .tvalid_o(rx_tvalid)
    );

    assign n_bytes   = we_q ? 4'd9 : 4'd5;
    assign tx_tvalid = (state_q == ST_SEND) && (byte_idx_q < n_bytes);
    assign wb_ack_o  = (state_q == ST_DONE);
    assign wb_err_o  = (state_q == ST_FAIL);
    assign wb_data_o = rdata_q;

    always_comb begin
        case (byte_idx_q)
            4'd0:    tx_tdata = we_q ? 8'h57 : 8'h52;
            4'd1:    tx_tdata = addr_q[7:0];
            4'd2:    tx_tdata = addr_q[15:8];
            4'd3:    tx_tdata = addr_q[23:16];
            4'd4:    tx_tdata = addr_q[31:24];
            4'd5:    tx_tdata = wdata_q[7:0];
            4'd6:    tx_tdata = wdata_q[15:8];
            4'd7:    tx_tdata = wdata_q[23:16];
            4'd8:    tx_tdata = wdata_q[31:24];
            default: tx_tdata = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        byte_idx_d = byte_idx_q;
        rcnt_d     = rcnt_q;
        resp_d     = resp_q;
        tmo_d      = tmo_q;
        rdata_d    = rdata_q;
        case (state_q)
            ST_IDLE: if (wb_cyc_i && wb_strobe_i) begin
                state_d    = ST_SEND;
                addr_d     = wb_addr_i;
                wdata_d    = wb_data_i;
                we_d       = wb_we_i;
                byte_idx_d = 4'd0;
            end
            ST_SEND: begin
                if (tx_tvalid && tx_tready) begin
                    byte_idx_d = byte_idx_q + 4'd1;
                end else if ((byte_idx_q == n_bytes) && tx_frame_end) begin
                    state_d = ST_WAIT;
                    tmo_d   = '0;
                    rcnt_d  = 2'd0;
                end
            end
            ST_WAIT: begin
                tmo_d = tmo_q + TW'(1);
                // A deciding byte beats a timeout expiring in the same cycle.
                if (rx_tvalid) begin
                    resp_d = {rx_tdata, resp_q[31:8]};
                    if (we_q) begin
                        state_d = (rx_tdata == 8'h4B) ? ST_DONE : ST_FAIL;
                    end else if (rcnt_q == 2'd3) begin
                        state_d = ST_DONE;
                        rdata_d = resp_d;
                    end else begin
                        rcnt_d = rcnt_q + 2'd1;
                    end
                end else if (tmo_q >= TMO_LAST) begin
                    state_d = ST_FAIL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            byte_idx_q <= '0;
            rcnt_q     <= '0;
            resp_q     <= '0;
            tmo_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            byte_idx_q <= byte_idx_d;
            rcnt_q     <= rcnt_d;
            resp_q     <= resp_d;
            tmo_q      <= tmo_d;
            rdata_q    <= rdata_d;
        end
    end
endmodule
